// File: rtl/ca_pkg.sv
// Shared constants, state encoding and G1/G2 tap definitions for the C/A code blocks.
// Used by both the code generator and the code-phase search.
package ca_pkg;

    localparam int CODE_LEN = 1023;
    localparam int PHASE_W  = 10;
    localparam int AGREE_W  = 11;
    localparam int TAP_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTEG,
        S_EVAL,
        S_SLIP,
        S_LOCK,
        S_FAIL
    } state_t;

    // Feedback masks, bit i set means stage i feeds the XOR (G1: 3,10; G2: 2,3,6,8,9,10)
    localparam logic [10:1] G1_FB = 10'b10_0000_0100;
    localparam logic [10:1] G2_FB = 10'b11_1010_0110;

    // G2 phase-select taps {t0,t1} for PRN 1..32, one nibble each (A = stage 10)
    localparam logic [7:0] PRN_TAP_TBL [32] = '{
        8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
        8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
        8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
        8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
    };

    function automatic logic [7:0] prn_taps(input int unsigned prn);
        logic [4:0] idx;
        idx = 5'(prn - 1);
        return PRN_TAP_TBL[idx];
    endfunction

    // Out-of-range tap selects read as 0 rather than X.
    function automatic logic tap_sel(input logic [10:1] g, input logic [TAP_W-1:0] t);
        logic b;
        b = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (t == TAP_W'(i)) b = g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/ca_code_sync_gen.sv
// G1/G2 LFSR pair producing the C/A chip for the selected G2 taps; shifts only on adv.
// load returns both registers to all ones (chip index 0), taking priority over adv.
module ca_gen
    import ca_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    input  logic [TAP_W-1:0] t0,
    input  logic [TAP_W-1:0] t1,
    output logic             chip,
    output logic             zero_idx
);

    logic [10:1] g1_q, g1_d;
    logic [10:1] g2_q, g2_d;

    always_comb begin
        g1_d = g1_q;
        g2_d = g2_q;
        if (load) begin
            g1_d = '1;
            g2_d = '1;
        end else if (adv) begin
            g1_d = {g1_q[9:1], ^(g1_q & G1_FB)};
            g2_d = {g2_q[9:1], ^(g2_q & G2_FB)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            g1_q <= '1;
            g2_q <= '1;
        end else begin
            g1_q <= g1_d;
            g2_q <= g2_d;
        end
    end

    assign chip     = g1_q[10] ^ tap_sel(g2_q, t0) ^ tap_sel(g2_q, t1);
    assign zero_idx = (&g1_q) & (&g2_q);

endmodule

// File: rtl/ca_code_sync.sv
// Serial C/A code-phase search: correlate one full period per candidate, slip one chip on miss.
// Lock is flagged 2 cycles after the last chip of the matching period.
module ca_code_sync
    import ca_pkg::*;
#(
    parameter int THRESH    = 900,
    parameter int MAX_SLIPS = 1023
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [TAP_W-1:0]   t0,
    input  logic [TAP_W-1:0]   t1,
    input  logic               chip_in,
    input  logic               chip_vld,
    output logic               busy,
    output logic               locked,
    output logic               fail,
    output logic               inverted,
    output logic [PHASE_W-1:0] code_phase,
    output logic [AGREE_W-1:0] agree,
    output logic               local_chip,
    output logic               epoch
);

    localparam logic [AGREE_W-1:0] AGREE_HI   = AGREE_W'(THRESH);
    localparam logic [AGREE_W-1:0] AGREE_LO   = AGREE_W'(CODE_LEN - THRESH);
    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(MAX_SLIPS - 1);
    localparam logic [PHASE_W-1:0] LAST_CHIP  = PHASE_W'(CODE_LEN - 1);

    state_t             state_q, state_d;
    logic [TAP_W-1:0]   t0_q, t0_d, t1_q, t1_d;
    logic [PHASE_W-1:0] chip_cnt_q, chip_cnt_d;
    logic [PHASE_W-1:0] code_phase_q, code_phase_d;
    logic [AGREE_W-1:0] agree_acc_q, agree_acc_d;
    logic [AGREE_W-1:0] agree_q, agree_d;
    logic               busy_q, busy_d;
    logic               locked_q, locked_d;
    logic               fail_q, fail_d;
    logic               inverted_q, inverted_d;
    logic               gen_load, gen_adv, gen_chip, gen_zero;
    logic               hit;
    logic [AGREE_W-1:0] acc_inc;

    ca_gen u_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (gen_load),
        .adv      (gen_adv),
        .t0       (t0_q),
        .t1       (t1_q),
        .chip     (gen_chip),
        .zero_idx (gen_zero)
    );

    assign hit     = ~(chip_in ^ gen_chip);
    assign acc_inc = agree_acc_q + AGREE_W'(hit);

    always_comb begin
        state_d      = state_q;
        t0_d         = t0_q;
        t1_d         = t1_q;
        chip_cnt_d   = chip_cnt_q;
        code_phase_d = code_phase_q;
        agree_acc_d  = agree_acc_q;
        agree_d      = agree_q;
        busy_d       = busy_q;
        locked_d     = locked_q;
        fail_d       = fail_q;
        inverted_d   = inverted_q;
        gen_load     = 1'b0;
        gen_adv      = 1'b0;

        if (start) begin
            t0_d         = t0;
            t1_d         = t1;
            gen_load     = 1'b1;
            chip_cnt_d   = '0;
            agree_acc_d  = '0;
            code_phase_d = '0;
            locked_d     = 1'b0;
            fail_d       = 1'b0;
            inverted_d   = 1'b0;
            busy_d       = 1'b1;
            state_d      = S_INTEG;
        end else begin
            case (state_q)
                S_INTEG: begin
                    if (chip_vld) begin
                        gen_adv     = 1'b1;
                        agree_acc_d = acc_inc;
                        if (chip_cnt_q == LAST_CHIP) begin
                            chip_cnt_d = '0;
                            state_d    = S_EVAL;
                        end else begin
                            chip_cnt_d = chip_cnt_q + 1'b1;
                        end
                    end
                end
                S_EVAL: begin
                    agree_d = agree_acc_q;
                    if (agree_acc_q >= AGREE_HI || agree_acc_q <= AGREE_LO) begin
                        // A chip arriving now is already the first chip of the locked period
                        locked_d    = 1'b1;
                        busy_d      = 1'b0;
                        inverted_d  = (agree_acc_q < AGREE_HI);
                        gen_adv     = chip_vld;
                        agree_acc_d = chip_vld ? AGREE_W'(hit) : '0;
                        chip_cnt_d  = chip_vld ? PHASE_W'(1) : '0;
                        state_d     = S_LOCK;
                    end else if (code_phase_q == LAST_PHASE) begin
                        fail_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_FAIL;
                    end else if (chip_vld) begin
                        code_phase_d = code_phase_q + 1'b1;
                        agree_acc_d  = '0;
                        chip_cnt_d   = '0;
                        state_d      = S_INTEG;
                    end else begin
                        state_d = S_SLIP;
                    end
                end
                S_SLIP: begin
                    if (chip_vld) begin
                        code_phase_d = code_phase_q + 1'b1;
                        agree_acc_d  = '0;
                        chip_cnt_d   = '0;
                        state_d      = S_INTEG;
                    end
                end
                S_LOCK: begin
                    if (chip_vld) begin
                        gen_adv = 1'b1;
                        if (chip_cnt_q == LAST_CHIP) begin
                            agree_d     = acc_inc;
                            agree_acc_d = '0;
                            chip_cnt_d  = '0;
                        end else begin
                            agree_acc_d = acc_inc;
                            chip_cnt_d  = chip_cnt_q + 1'b1;
                        end
                    end
                end
                S_IDLE, S_FAIL: begin
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            t0_q         <= '0;
            t1_q         <= '0;
            chip_cnt_q   <= '0;
            code_phase_q <= '0;
            agree_acc_q  <= '0;
            agree_q      <= '0;
            busy_q       <= 1'b0;
            locked_q     <= 1'b0;
            fail_q       <= 1'b0;
            inverted_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            t0_q         <= t0_d;
            t1_q         <= t1_d;
            chip_cnt_q   <= chip_cnt_d;
            code_phase_q <= code_phase_d;
            agree_acc_q  <= agree_acc_d;
            agree_q      <= agree_d;
            busy_q       <= busy_d;
            locked_q     <= locked_d;
            fail_q       <= fail_d;
            inverted_q   <= inverted_d;
        end
    end

    assign busy       = busy_q;
    assign locked     = locked_q;
    assign fail       = fail_q;
    assign inverted   = inverted_q;
    assign code_phase = code_phase_q;
    assign agree      = agree_q;
    assign local_chip = gen_chip;
    assign epoch      = gen_adv & gen_zero;

endmodule

// File: tb/tb_ca_code_sync.sv
// Directed bench for ca_code_sync: two instances (default and relaxed/short search) share one chip stream.
module tb_ca_code_sync;
    import ca_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, chip_in, chip_vld;
    logic [3:0]  t0, t1;

    logic        a_busy, a_locked, a_fail, a_inverted, a_local_chip, a_epoch;
    logic [9:0]  a_code_phase;
    logic [10:0] a_agree;
    logic        b_busy, b_locked, b_fail, b_inverted, b_local_chip, b_epoch;
    logic [9:0]  b_code_phase;
    logic [10:0] b_agree;

    always #5 clk = ~clk;

    ca_code_sync #(.THRESH(900), .MAX_SLIPS(1023)) dut (
        .clk(clk), .rst(rst), .start(start), .t0(t0), .t1(t1),
        .chip_in(chip_in), .chip_vld(chip_vld),
        .busy(a_busy), .locked(a_locked), .fail(a_fail), .inverted(a_inverted),
        .code_phase(a_code_phase), .agree(a_agree),
        .local_chip(a_local_chip), .epoch(a_epoch)
    );

    ca_code_sync #(.THRESH(640), .MAX_SLIPS(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .t0(t0), .t1(t1),
        .chip_in(chip_in), .chip_vld(chip_vld),
        .busy(b_busy), .locked(b_locked), .fail(b_fail), .inverted(b_inverted),
        .code_phase(b_code_phase), .agree(b_agree),
        .local_chip(b_local_chip), .epoch(b_epoch)
    );

    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         sel = 0;
    int         ep_err, ep_cnt, lock_cyc, match_cyc;
    logic [9:0] first10;
    bit         code [0:1022];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference PRN1 code (G2 taps 2 and 6), built independently of the RTL.
    task automatic build_code();
        bit [10:1] g1;
        bit [10:1] g2;
        g1 = '1;
        g2 = '1;
        for (int i = 0; i < 1023; i++) begin
            code[i] = g1[10] ^ g2[2] ^ g2[6];
            g1 = {g1[9:1], g1[3] ^ g1[10]};
            g2 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
        end
    endtask

    task automatic sample(input bit vld, input bit ep_exp);
        logic lk, ep;
        lk = (sel != 0) ? b_locked : a_locked;
        ep = (sel != 0) ? b_epoch : a_epoch;
        if (lk === 1'b1 && lock_cyc < 0) lock_cyc = cyc;
        if (lk === 1'b1) begin
            if (ep !== (vld & ep_exp)) ep_err++;
            if (ep === 1'b1) ep_cnt++;
        end
    endtask

    // Stream index n carries reference chip (n - d) mod 1023, optionally inverted, every third flipped, or random.
    task automatic run(input int d, input bit inv, input bit noisy, input bit rnd,
                       input bit gaps, input int nchips);
        bit c;
        int idx, g;
        ep_err = 0; ep_cnt = 0; lock_cyc = -1; match_cyc = -1;
        for (int n = 0; n < nchips; n++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    chip_vld = 1'b0;
                    chip_in  = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    sample(1'b0, 1'b0);
                    @(posedge clk); #1;
                end
            end
            idx = ((n - d) % 1023 + 1023) % 1023;
            c = rnd ? 1'($urandom_range(0, 1)) : code[idx];
            c = c ^ inv;
            if (noisy && (n % 3 == 0)) c = ~c;
            chip_in  = c;
            chip_vld = 1'b1;
            if (n == d * 1024 + 1022) match_cyc = cyc;
            @(negedge clk);
            if (n < 10) first10 = {first10[8:0], a_local_chip};
            sample(1'b1, idx == 0);
            @(posedge clk); #1;
        end
        chip_vld = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] taps;
        build_code();
        taps     = prn_taps(1);
        t0       = taps[7:4];
        t1       = taps[3:0];
        rst      = 1'b1;
        start    = 1'b0;
        chip_vld = 1'b0;
        chip_in  = 1'b0;
        first10  = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", a_busy, 0);
        chk("rst_locked", a_locked, 0);
        chk("rst_fail", a_fail, 0);
        chk("rst_inverted", a_inverted, 0);
        chk("rst_code_phase", a_code_phase, 0);
        chk("rst_agree", a_agree, 0);
        chk("rst_local_chip", a_local_chip, 1);
        chk("rst_epoch", a_epoch, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Delay 5, clean stream
        pulse_start();
        @(negedge clk);
        chk("a_start_busy", a_busy, 1);
        @(posedge clk); #1;
        sel = 0;
        run(5, 1'b0, 1'b0, 1'b0, 1'b0, 8243);
        @(negedge clk);
        chk("a_prn1_first10", first10, 10'b1100100000);
        chk("a_locked", a_locked, 1);
        chk("a_code_phase", a_code_phase, 5);
        chk("a_agree", a_agree, 1023);
        chk("a_inverted", a_inverted, 0);
        chk("a_busy", a_busy, 0);
        chk("a_fail", a_fail, 0);
        chk("a_lock_latency", lock_cyc - match_cyc, 2);
        chk("a_epoch_align_err", ep_err, 0);
        chk("a_epoch_count", ep_cnt, 2);
        chk("b_short_fail", b_fail, 1);
        chk("b_short_phase", b_code_phase, 3);
        chk("b_short_locked", b_locked, 0);
        chk("b_short_busy", b_busy, 0);

        // Same stream complemented; start also aborts the held lock
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("inv_restart_locked", a_locked, 0);
        chk("inv_restart_phase", a_code_phase, 0);
        @(posedge clk); #1;
        run(5, 1'b1, 1'b0, 1'b0, 1'b0, 6200);
        @(negedge clk);
        chk("inv_locked", a_locked, 1);
        chk("inv_inverted", a_inverted, 1);
        chk("inv_agree", a_agree, 0);
        chk("inv_code_phase", a_code_phase, 5);

        // Delay 3 with every third chip flipped: agree 682 at match
        @(posedge clk); #1;
        pulse_start();
        @(posedge clk); #1;
        sel = 1;
        run(3, 1'b0, 1'b1, 1'b0, 1'b0, 5110);
        @(negedge clk);
        chk("noisy_b_locked", b_locked, 1);
        chk("noisy_b_phase", b_code_phase, 3);
        chk("noisy_b_agree", b_agree, 682);
        chk("noisy_b_inverted", b_inverted, 0);
        chk("noisy_b_lock_latency", lock_cyc - match_cyc, 2);
        chk("noisy_b_epoch_err", ep_err, 0);
        chk("noisy_a_locked", a_locked, 0);
        chk("noisy_a_busy", a_busy, 1);
        chk("noisy_a_phase", a_code_phase, 4);
        chk("noisy_a_agree", a_agree, 682);

        // Random chips: short search fails; then start mid-INTEG and find delay 2
        @(posedge clk); #1;
        pulse_start();
        @(posedge clk); #1;
        sel = 0;
        run(0, 1'b0, 1'b0, 1'b1, 1'b0, 4200);
        @(negedge clk);
        chk("rnd_b_fail", b_fail, 1);
        chk("rnd_b_locked", b_locked, 0);
        chk("rnd_b_busy", b_busy, 0);
        chk("rnd_b_phase", b_code_phase, 3);
        chk("rnd_a_phase", a_code_phase, 4);
        chk("rnd_a_busy", a_busy, 1);
        @(posedge clk); #1;
        pulse_start();
        @(negedge clk);
        chk("mid_a_phase", a_code_phase, 0);
        chk("mid_a_busy", a_busy, 1);
        chk("mid_b_fail", b_fail, 0);
        chk("mid_b_busy", b_busy, 1);
        @(posedge clk); #1;
        run(2, 1'b0, 1'b0, 1'b0, 1'b0, 3081);
        @(negedge clk);
        chk("d2_a_locked", a_locked, 1);
        chk("d2_a_phase", a_code_phase, 2);
        chk("d2_a_lock_latency", lock_cyc - match_cyc, 2);
        chk("d2_b_locked", b_locked, 1);
        chk("d2_b_phase", b_code_phase, 2);

        // Delay 17 with random gaps between valid chips
        @(posedge clk); #1;
        pulse_start();
        @(posedge clk); #1;
        run(17, 1'b0, 1'b0, 1'b0, 1'b1, 19531);
        @(negedge clk);
        chk("gap_locked", a_locked, 1);
        chk("gap_phase", a_code_phase, 17);
        chk("gap_agree", a_agree, 1023);
        chk("gap_lock_latency", lock_cyc - match_cyc, 2);
        chk("gap_epoch_err", ep_err, 0);
        chk("gap_epoch_seen", ep_cnt >= 1, 1);

        // rst while locked, with start asserted in the same cycle
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst2_busy", a_busy, 0);
        chk("rst2_locked", a_locked, 0);
        chk("rst2_code_phase", a_code_phase, 0);
        chk("rst2_agree", a_agree, 0);
        chk("rst2_local_chip", a_local_chip, 1);
        chk("rst2_epoch", a_epoch, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
